// File: rtl/uart_tx_pkg.sv
// ============================================================================
// Module      : uart_tx_pkg
// Description : Shared FSM state encoding and framing constants for the UART.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int DATA_BITS = 8;

endpackage : uart_tx_pkg

`default_nettype wire

// File: rtl/uart_tx_if.sv
// ============================================================================
// Module      : uart_tx_if
// Description : Byte write port and serial/status outputs of the transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_if;

  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;
  logic       busy_o;
  logic       tx_o;

  modport master (
    output data_i,
    output valid_i,
    input  ready_o,
    input  busy_o,
    input  tx_o
  );

  modport slave (
    input  data_i,
    input  valid_i,
    output ready_o,
    output busy_o,
    output tx_o
  );

endinterface : uart_tx_if

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module      : uart_tx_fifo
// Description : Small synchronous FIFO; full/empty derived from the count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  wire              clk_i,
  input  wire              rst_i,
  input  wire              i_push,
  input  wire  [WIDTH-1:0] i_data,
  input  wire              i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  // Pushes while full are dropped; power-of-two depth lets pointers wrap freely.
  assign w_push  = i_push && (r_count != c_DEPTH);
  assign w_pop   = i_pop  && (r_count != '0);

  assign o_full  = (r_count == c_DEPTH);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule : uart_tx_fifo

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// Module      : uart_tx
// Description : 8N1 UART transmitter, LSB first, fed from a small byte FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 234,
  parameter int FIFO_DEPTH   = 4
) (
  input  wire       clk_i,
  input  wire       rst_i,
  uart_tx_if.slave  bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] c_BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    c_BIT_LAST  = 3'(DATA_BITS - 1);

  tx_state_e     r_state;
  tx_state_e     w_state_nxt;
  logic [CW-1:0] r_baud;
  logic [CW-1:0] w_baud_nxt;
  logic [2:0]    r_bit_idx;
  logic [2:0]    w_bit_nxt;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_nxt;
  logic          r_tx;
  logic          w_tx_nxt;

  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [AW:0]   w_count;
  logic [7:0]    w_head;
  logic          w_bit_end;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (bus.valid_i),
    .i_data  (bus.data_i),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign bus.ready_o = !w_full;
  assign bus.busy_o  = (r_state != ST_IDLE) || (w_count != '0);
  assign bus.tx_o    = r_tx;

  assign w_bit_end   = (r_baud == c_BAUD_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_baud    <= w_baud_nxt;
      r_bit_idx <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_tx      <= w_tx_nxt;
    end
  end

  // Every state change happens on a bit boundary, so wrapping the baud counter
  // there also clears it on each transition.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = w_bit_end ? '0 : r_baud + 1'b1;
    w_bit_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_baud_nxt = '0;
        w_tx_nxt   = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_state_nxt = ST_START;
          w_tx_nxt    = 1'b0;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_nxt = ST_DATA;
          w_bit_nxt   = '0;
          w_tx_nxt    = r_shift[0];
          w_shift_nxt = {1'b0, r_shift[7:1]};
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          if (r_bit_idx == c_BIT_LAST) begin
            w_state_nxt = ST_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_nxt   = r_bit_idx + 1'b1;
            w_tx_nxt    = r_shift[0];
            w_shift_nxt = {1'b0, r_shift[7:1]};
          end
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_state_nxt = ST_START;
            w_tx_nxt    = 1'b0;
          end else begin
            w_state_nxt = ST_IDLE;
            w_tx_nxt    = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

endmodule : uart_tx

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
// Module      : tb_uart_tx
// Description : Randomised self-checking bench with frame-level line model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_if u_if ();

  uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (u_if.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference: queue of waiting bytes plus position inside the current frame.
  logic [7:0] m_q[$];
  logic [7:0] m_rxq[$];
  logic [7:0] m_cur    = 8'h00;
  logic       m_active = 1'b0;
  int         m_pos    = 0;
  int         m_acc    = 0;
  logic       m_tx     = 1'b1;
  logic       m_ready  = 1'b1;
  logic       m_busy   = 1'b0;

  logic       rx_active = 1'b0;
  int         rx_t      = 0;
  logic [7:0] rx_byte   = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return b[idx-1];
  endfunction

  task automatic model_edge(input logic v, input logic [7:0] d, input logic r);
    logic pop_now;
    logic acc;
    if (r) begin
      m_q.delete();
      m_rxq.delete();
      m_active  = 1'b0;
      m_pos     = 0;
      rx_active = 1'b0;
    end else begin
      pop_now = (m_q.size() > 0) && (!m_active || m_pos == FRAME - 1);
      acc     = v && (m_q.size() < DEPTH);
      if (pop_now) begin
        m_cur    = m_q.pop_front();
        m_active = 1'b1;
        m_pos    = 0;
      end else if (m_active) begin
        if (m_pos == FRAME - 1) m_active = 1'b0;
        else                    m_pos++;
      end
      if (acc) begin
        m_q.push_back(d);
        m_rxq.push_back(d);
        m_acc++;
      end
    end
    m_tx    = m_active ? frame_bit(m_cur, m_pos / CPB) : 1'b1;
    m_ready = (m_q.size() < DEPTH);
    m_busy  = m_active || (m_q.size() != 0);
  endtask

  // Mid-bit sampling receiver on the observed line.
  task automatic rx_sample();
    logic [31:0] exp;
    int k;
    if (!rx_active) begin
      if (u_if.tx_o === 1'b0) begin
        rx_active = 1'b1;
        rx_t      = 0;
        rx_byte   = 8'h00;
      end
    end else begin
      rx_t++;
    end
    if (rx_active && (rx_t % CPB) == CPB / 2) begin
      k = rx_t / CPB;
      if (k == 0) begin
        chk("rx_start", {31'd0, u_if.tx_o}, 32'd0);
      end else if (k <= 8) begin
        rx_byte[k-1] = u_if.tx_o;
      end else begin
        chk("rx_stop", {31'd0, u_if.tx_o}, 32'd1);
        exp = (m_rxq.size() > 0) ? {24'd0, m_rxq.pop_front()} : 32'h100;
        chk("rx_byte", {24'd0, rx_byte}, exp);
        rx_active = 1'b0;
      end
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic r);
    u_if.valid_i = v;
    u_if.data_i  = d;
    rst          = r;
    @(posedge clk);
    model_edge(v, d, r);
    #1;
    chk("tx",    {31'd0, u_if.tx_o},    {31'd0, m_tx});
    chk("ready", {31'd0, u_if.ready_o}, {31'd0, m_ready});
    chk("busy",  {31'd0, u_if.busy_o},  {31'd0, m_busy});
    if (!r) rx_sample();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    logic [7:0] burst [5];
    int a0;
    int cyc;
    u_if.valid_i = 1'b0;
    u_if.data_i  = 8'h00;

    // Reset held two cycles
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("rst_tx",    {31'd0, u_if.tx_o},    32'd1);
    chk("rst_ready", {31'd0, u_if.ready_o}, 32'd1);
    chk("rst_busy",  {31'd0, u_if.busy_o},  32'd0);

    // Single 0x55 frame
    step(1'b1, 8'h55, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("t2_start_low", {31'd0, u_if.tx_o}, 32'd0);
    idle(45);
    chk("t2_idle_busy", {31'd0, u_if.busy_o}, 32'd0);

    // Five bytes on consecutive cycles, frames back-to-back
    burst = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81};
    a0 = m_acc;
    for (int i = 0; i < 5; i++) step(1'b1, burst[i], 1'b0);
    chk("t3_accepted", m_acc - a0, 32'd5);
    idle(5 * FRAME + 10);

    // Fill FIFO behind a running frame, then offer 0x77 only while full
    for (int i = 0; i < 5; i++) step(1'b1, 8'h11 * (i + 1), 1'b0);
    a0 = m_acc;
    for (int i = 0; i < 12; i++) begin
      if (m_q.size() == DEPTH) step(1'b1, 8'h77, 1'b0);
      else                     step(1'b0, 8'h00, 1'b0);
    end
    chk("t4_no_accept", m_acc - a0, 32'd0);
    idle(5 * FRAME + 10);

    // Reset 13 cycles into a 0x0F frame, then a clean 0x12
    step(1'b1, 8'h0F, 1'b0);
    idle(13);
    step(1'b0, 8'h00, 1'b1);
    chk("t5_rst_tx",   {31'd0, u_if.tx_o},   32'd1);
    chk("t5_rst_busy", {31'd0, u_if.busy_o}, 32'd0);
    step(1'b1, 8'h12, 1'b0);
    idle(FRAME + 10);
    chk("t5_left", m_rxq.size(), 32'd0);

    // 200 random bytes with random valid gaps
    a0  = m_acc;
    cyc = 0;
    while ((m_acc - a0) < 200 && cyc < 30000) begin
      step(($urandom_range(0, 3) != 0), 8'($urandom), 1'b0);
      cyc++;
    end
    chk("t6_accepted", m_acc - a0, 32'd200);
    idle((DEPTH + 1) * FRAME + 10);
    chk("t6_left", m_rxq.size(), 32'd0);
    chk("t6_idle", {31'd0, u_if.busy_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_uart_tx

`default_nettype wire
